ro_freq_meter: RTL and testbench

RO_FREQ_METER -- requirements
Module: ro_freq_meter

---
 rtl/ro_freq_meter.sv | 134 +++++++++++++
 tb/tb_ro_freq_meter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of ro_in
// over a programmable gate window of 16 << gate_sel clk cycles.
module ro_freq_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2    // legal range 2..4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             ro_in,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned TMR_W  = 11;  // holds G-1 up to 2047
  localparam int unsigned GLEN_W = 12;  // holds G up to 2048
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     prev_q;
  logic                     edge_c;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [CNT_W-1:0]         wcnt_q, wcnt_d;
  logic                     wovf_q, wovf_d;
  logic                     busy_d, done_d;
  logic [CNT_W-1:0]         count_d;
  logic                     overflow_d;
  logic [GLEN_W-1:0]        gate_len_c;

  // Free-running synchronizer and edge-detect flop, independent of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      wcnt_q   <= '0;
      wovf_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wcnt_q   <= wcnt_d;
      wovf_q   <= wovf_d;
      busy     <= busy_d;
      done     <= done_d;
      count    <= count_d;
      overflow <= overflow_d;
    end
  end

  // Next-state and next-output logic; ena low overrides everything to idle.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    wcnt_d     = wcnt_q;
    wovf_d     = wovf_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    count_d    = count;
    overflow_d = overflow;
    gate_len_c = GLEN_W'(16) << gate_sel;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          timer_d = TMR_W'(gate_len_c - GLEN_W'(1));
          wcnt_d  = '0;
          wovf_d  = 1'b0;
          state_d = ST_COUNT;
          busy_d  = 1'b1;
        end
      end
      ST_COUNT: begin
        busy_d = 1'b1;
        // Saturate rather than wrap; a saturated edge flags overflow.
        if (edge_c) begin
          if (wcnt_q == CNT_MAX) wovf_d = 1'b1;
          else                   wcnt_d = wcnt_q + CNT_W'(1);
        end
        if (timer_q == '0) begin
          // Last window cycle: its edge is already folded into wcnt_d/wovf_d.
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          count_d    = wcnt_d;
          overflow_d = wovf_d;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!ena) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      count_d    = count;
      overflow_d = overflow;
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: two instances (16-bit/2-stage and 4-bit/3-stage)
// share stimulus; results are checked against an edge-counting model over the
// recorded history of ro_in samples.
module tb_ro_freq_meter;

  localparam int unsigned HIST_N = 30000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        ro_in;
  logic        start;
  logic [2:0]  gate_sel;
  logic        busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic        busy_b, done_b, ovf_b;
  logic [3:0]  count_b;

  int n_cmp = 0;
  int n_err = 0;

  // ro_in generator control: 0 hold low, 1 square wave, 2 random bits
  int ro_mode = 0;
  int ro_half = 2;

  // history of ro_in as seen at each rising clk edge (0 while in reset)
  bit hist [HIST_N];
  int cyc      = 0;
  int rst_mark = 0;

  // expected retained results
  int prev_a    = 0;
  int prev_b    = 0;
  bit prev_ova  = 1'b0;
  bit prev_ovb  = 1'b0;

  ro_freq_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start),
    .gate_sel(gate_sel), .busy(busy_a), .done(done_a), .count(count_a),
    .overflow(ovf_a)
  );

  ro_freq_meter #(.CNT_W(4), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start),
    .gate_sel(gate_sel), .busy(busy_b), .done(done_b), .count(count_b),
    .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cyc < int'(HIST_N)) hist[cyc] <= rst_n ? ro_in : 1'b0;
    cyc <= cyc + 1;
  end

  // ro_in source, changes only on falling clk edges
  initial begin
    int ph;
    ph = 0;
    ro_in = 1'b0;
    forever begin
      @(negedge clk);
      case (ro_mode)
        1: begin
          ph = ph + 1;
          if (ph >= ro_half) begin
            ph = 0;
            ro_in = ~ro_in;
          end
        end
        2:       ro_in = 1'($urandom_range(0, 1));
        default: ro_in = 1'b0;
      endcase
    end
  end

  function automatic bit h(input int j);
    if (j < 0 || j < rst_mark || j >= int'(HIST_N)) return 1'b0;
    return hist[j];
  endfunction

  // Rising transitions of the synchronized stream seen during the G window
  // cycles that follow the start edge e0, for an s-stage synchronizer.
  function automatic int model_edges(input int e0, input int g, input int s);
    int n;
    n = 0;
    for (int k = e0; k < e0 + g; k++)
      if (h(k - s + 1) && !h(k - s)) n++;
    return n;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; gate_sel = 3'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_a, done_a, ovf_a, busy_b, done_b, ovf_b} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 000000",
               {busy_a, done_a, ovf_a, busy_b, done_b, ovf_b});
    end
    n_cmp++;
    if (count_a !== 16'd0 || count_b !== 4'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d/%0d required 0/0", count_a, count_b);
    end
    rst_n = 1'b1;
    ena   = 1'b1;
  endtask

  // One full measurement; exp_a/exp_b < 0 means "model only".
  task automatic do_measure(input logic [2:0] gsel, input int exp_a,
                            input int exp_b, input bit poke_count,
                            input bit poke_done, input string name);
    int g, e0, na, nb, bad_busy, bad_hold, ea, eb;
    bit oa, ob;
    g = 16 << gsel;
    bad_busy = 0;
    bad_hold = 0;
    @(negedge clk);
    gate_sel = gsel;
    start    = 1'b1;
    e0       = cyc;
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      start    = 1'b0;
      gate_sel = 3'($urandom);
      if (poke_count && i == g / 2) start = 1'b1;
      if (busy_a !== 1'b1 || busy_b !== 1'b1 || done_a !== 1'b0 || done_b !== 1'b0)
        bad_busy++;
      if (count_a !== 16'(prev_a) || count_b !== 4'(prev_b) ||
          ovf_a !== prev_ova || ovf_b !== prev_ovb)
        bad_hold++;
    end
    @(negedge clk);
    na = model_edges(e0, g, 2);
    nb = model_edges(e0, g, 3);
    ea = (na > 65535) ? 65535 : na;
    oa = (na > 65535);
    eb = (nb > 15) ? 15 : nb;
    ob = (nb > 15);
    n_cmp++;
    if (bad_busy !== 0) begin
      n_err++;
      $display("FAIL %s busy_window: %0d bad cycles of %0d, required 0", name, bad_busy, g);
    end
    n_cmp++;
    if (bad_hold !== 0) begin
      n_err++;
      $display("FAIL %s result_hold: %0d cycles changed, required 0", name, bad_hold);
    end
    n_cmp++;
    if (done_a !== 1'b1 || done_b !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_pulse: done %b%b busy %b%b required 11 00",
               name, done_a, done_b, busy_a, busy_b);
    end
    n_cmp++;
    if (count_a !== 16'(ea) || ovf_a !== oa) begin
      n_err++;
      $display("FAIL %s result16: got %0d ovf %b required %0d ovf %b",
               name, count_a, ovf_a, ea, oa);
    end
    n_cmp++;
    if (count_b !== 4'(eb) || ovf_b !== ob) begin
      n_err++;
      $display("FAIL %s result4: got %0d ovf %b required %0d ovf %b",
               name, count_b, ovf_b, eb, ob);
    end
    if (exp_a >= 0) begin
      n_cmp++;
      if (count_a !== 16'(exp_a)) begin
        n_err++;
        $display("FAIL %s known16: got %0d required %0d", name, count_a, exp_a);
      end
    end
    if (exp_b >= 0) begin
      n_cmp++;
      if (count_b !== 4'(exp_b) || ovf_b !== (exp_b == 15)) begin
        n_err++;
        $display("FAIL %s known4: got %0d ovf %b required %0d", name, count_b, ovf_b, exp_b);
      end
    end
    prev_a = ea; prev_ova = oa;
    prev_b = eb; prev_ovb = ob;
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done_a !== 1'b0 || done_b !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: done %b%b busy %b%b required 00 00",
               name, done_a, done_b, busy_a, busy_b);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed;
    ro_mode = 1; ro_half = 2;
    do_measure(3'd0, 4, 4, 1'b0, 1'b0, "p4_g16");
    ro_half = 4;
    do_measure(3'd3, 16, -1, 1'b0, 1'b0, "p8_g128");
    ro_mode = 0;
    repeat (8) @(negedge clk);
    do_measure(3'd0, 0, 0, 1'b0, 1'b0, "held_low");
    ro_mode = 1; ro_half = 2;
    do_measure(3'd0, 4, 4, 1'b0, 1'b0, "p4_again");
    do_measure(3'd2, 16, 15, 1'b0, 1'b0, "p4_g64_sat");
  endtask

  task automatic test_ignored_start;
    ro_mode = 1; ro_half = 3;
    do_measure(3'd1, -1, -1, 1'b1, 1'b1, "start_ignored");
  endtask

  task automatic test_ena_drop;
    int bad;
    ro_mode = 1; ro_half = 1;
    @(negedge clk);
    gate_sel = 3'd2;
    start    = 1'b1;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    ena = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL ena_drop_busy: got %b%b required 00", busy_a, busy_b);
    end
    ena = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || done_b !== 1'b0 || busy_a !== 1'b0 ||
          count_a !== 16'(prev_a) || count_b !== 4'(prev_b) ||
          ovf_a !== prev_ova || ovf_b !== prev_ovb)
        bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL ena_drop_hold: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_async_reset;
    ro_mode = 1; ro_half = 2;
    @(negedge clk);
    gate_sel = 3'd1;
    start    = 1'b1;
    repeat (9) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy_a, done_a, ovf_a, busy_b, done_b, ovf_b} !== 6'b0 ||
        count_a !== 16'd0 || count_b !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset: busy %b%b done %b%b ovf %b%b count %0d/%0d required all 0",
               busy_a, busy_b, done_a, done_b, ovf_a, ovf_b, count_a, count_b);
    end
    rst_mark = cyc;
    #1 rst_n = 1'b1;
    prev_a = 0; prev_b = 0; prev_ova = 1'b0; prev_ovb = 1'b0;
    do_measure(3'd0, 4, 4, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      ro_mode = int'($urandom_range(1, 2));
      ro_half = int'($urandom_range(1, 6));
      do_measure(3'($urandom_range(0, 3)), -1, -1, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_ena_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
